// File: rtl/dart_sched_pkg.sv
// Shared types and helpers for the ready/urgent round-robin scheduler.
package dart_sched_pkg;

  // Scheduler FSM: idle, or one requester owns the resource.
  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } sched_state_e;

  // Ceiling log2, with a minimum of 1 so that vectors are never zero width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Binary index of a one-hot vector; returns 0 for an all-zero input.
  function automatic int unsigned onehot_to_index(input logic [63:0] onehot);
    int unsigned index;
    index = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (onehot[i]) begin
        index = index | i;
      end
    end
    return index;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping past N-1 back to 0.
module rr_pick
  import dart_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_any
);

  logic w_hit;

  // Two passes: indices at/above the pointer first, then the wrapped-around ones.
  always_comb begin
    o_gnt = '0;
    w_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_hit && i_req[i] && (i >= int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_hit && i_req[i]) begin
        o_gnt[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/sched_ready_rr.sv
// Registered fair scheduler for one shared resource: urgent class beats normal
// class, each class has its own round-robin pointer, long-waiting normal
// requesters are promoted to urgent, and a grant is held until released.
module sched_ready_rr
  import dart_sched_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned IW = clog2(N),
  localparam int unsigned CW = clog2(STARVE_LIMIT + 1)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [N-1:0]  i_ready,
  input  logic [N-1:0]  i_ready_urgent,
  input  logic          i_release,
  output logic [N-1:0]  o_sel,
  output logic          o_sel_valid,
  output logic          o_sel_urgent,
  output logic [IW-1:0] o_sel_index,
  output logic [N-1:0]  o_promoted
);

  sched_state_e  r_state, w_state_d;
  logic [N-1:0]  r_sel, w_sel_d;
  logic          r_sel_urgent, w_sel_urgent_d;
  logic [IW-1:0] r_sel_index, w_sel_index_d;
  logic [IW-1:0] r_urg_ptr, w_urg_ptr_d;
  logic [IW-1:0] r_norm_ptr, w_norm_ptr_d;
  logic [CW-1:0] r_cnt [N];

  logic [N-1:0]  w_req, w_eu, w_promoted;
  logic [N-1:0]  w_gnt_urg, w_gnt_norm, w_win;
  logic          w_any_urg, w_any_norm;
  logic          w_event;
  logic [IW-1:0] w_win_index, w_win_next;

  assign w_req = i_ready | i_ready_urgent;
  assign w_eu  = i_ready_urgent | (w_req & w_promoted);

  // A counter sitting at the limit marks its requester as promoted.
  always_comb begin
    w_promoted = '0;
    for (int i = 0; i < N; i++) begin
      w_promoted[i] = (r_cnt[i] == CW'(STARVE_LIMIT));
    end
  end

  rr_pick #(.N(N)) u_pick_urg (
    .i_req (w_eu),
    .i_ptr (r_urg_ptr),
    .o_gnt (w_gnt_urg),
    .o_any (w_any_urg)
  );

  rr_pick #(.N(N)) u_pick_norm (
    .i_req (w_req),
    .i_ptr (r_norm_ptr),
    .o_gnt (w_gnt_norm),
    .o_any (w_any_norm)
  );

  assign w_win       = w_any_urg ? w_gnt_urg : w_gnt_norm;
  assign w_win_index = IW'(onehot_to_index(64'(w_win)));
  assign w_win_next  = (w_win_index == IW'(N - 1)) ? '0 : w_win_index + IW'(1);

  // Arbitrate from idle on any request, or when the holder releases or drops its request.
  assign w_event = (r_state == StIdle) ? (|w_req)
                                       : (i_release || ((w_req & r_sel) == '0));

  // Next-state and next-grant selection; everything holds between events.
  always_comb begin
    w_state_d      = r_state;
    w_sel_d        = r_sel;
    w_sel_urgent_d = r_sel_urgent;
    w_sel_index_d  = r_sel_index;
    w_urg_ptr_d    = r_urg_ptr;
    w_norm_ptr_d   = r_norm_ptr;
    if (w_event) begin
      if (w_any_norm) begin
        w_state_d      = StGrant;
        w_sel_d        = w_win;
        w_sel_urgent_d = w_any_urg;
        w_sel_index_d  = w_win_index;
        if (w_any_urg) begin
          w_urg_ptr_d = w_win_next;
        end else begin
          w_norm_ptr_d = w_win_next;
        end
      end else begin
        w_state_d      = StIdle;
        w_sel_d        = '0;
        w_sel_urgent_d = 1'b0;
        w_sel_index_d  = '0;
      end
    end
  end

  // Grant, pointer and FSM state registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_sel        <= '0;
      r_sel_urgent <= 1'b0;
      r_sel_index  <= '0;
      r_urg_ptr    <= '0;
      r_norm_ptr   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_sel        <= w_sel_d;
      r_sel_urgent <= w_sel_urgent_d;
      r_sel_index  <= w_sel_index_d;
      r_urg_ptr    <= w_urg_ptr_d;
      r_norm_ptr   <= w_norm_ptr_d;
    end
  end

  // Starvation counters: count lost events while requesting, clear on win or idle requester.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!w_req[i]) begin
          r_cnt[i] <= '0;
        end else if (w_event) begin
          if (w_win[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] != CW'(STARVE_LIMIT)) begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign o_sel        = r_sel;
  assign o_sel_valid  = (r_state == StGrant);
  assign o_sel_urgent = r_sel_urgent;
  assign o_sel_index  = r_sel_index;
  assign o_promoted   = w_promoted;

endmodule

// File: tb/tb_sched_ready_rr.sv
// Directed bench for sched_ready_rr with N=4, STARVE_LIMIT=2.
module tb_sched_ready_rr;

  logic       clk;
  logic       rst;
  logic [3:0] ready;
  logic [3:0] ready_urgent;
  logic       rel;
  logic [3:0] sel;
  logic       sel_valid;
  logic       sel_urgent;
  logic [1:0] sel_index;
  logic [3:0] promoted;

  int total;
  int bad;

  sched_ready_rr #(
    .N            (4),
    .STARVE_LIMIT (2)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_ready        (ready),
    .i_ready_urgent (ready_urgent),
    .i_release      (rel),
    .o_sel          (sel),
    .o_sel_valid    (sel_valid),
    .o_sel_urgent   (sel_urgent),
    .o_sel_index    (sel_index),
    .o_promoted     (promoted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    ready        = '0;
    ready_urgent = '0;
    rel          = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    ready        = '0;
    ready_urgent = '0;
    rel          = 1'b0;
    #2;
    total++;
    if ({sel, sel_valid, sel_urgent, sel_index, promoted} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got sel=%b valid=%b urg=%b idx=%0d prom=%b want all zero",
               sel, sel_valid, sel_urgent, sel_index, promoted);
    end
    tick();
    rst   = 1'b0;
    ready = 4'b0100;
    tick();
    total++;
    if ({sel, sel_valid, sel_urgent, sel_index} !== {4'b0100, 1'b1, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL first_grant: got sel=%b valid=%b urg=%b idx=%0d want 0100 1 0 2",
               sel, sel_valid, sel_urgent, sel_index);
    end
    // Async reset while holding a grant must drop it before any clock edge.
    rst = 1'b1;
    #1;
    total++;
    if ({sel, sel_valid} !== 5'b0000_0) begin
      bad++;
      $display("FAIL reset_mid_grant: got sel=%b valid=%b want 0000 0", sel, sel_valid);
    end
    ready = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_normal_rr();
    logic [3:0] exp_sel [5];
    logic       exp_urg [5];
    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    // Limit 2 with four requesters promotes losers from the third event on.
    exp_urg = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      rel = 1'b1;
      total++;
      if ({sel, sel_valid, sel_urgent} !== {exp_sel[k], 1'b1, exp_urg[k]}) begin
        bad++;
        $display("FAIL normal_rr[%0d]: got sel=%b valid=%b urg=%b want %b 1 %b",
                 k, sel, sel_valid, sel_urgent, exp_sel[k], exp_urg[k]);
      end
    end
    rel   = 1'b0;
    ready = '0;
    tick();
  endtask

  task automatic test_urgent();
    do_reset();
    ready        = 4'b0011;
    ready_urgent = 4'b1000;
    tick();
    total++;
    if ({sel, sel_urgent, sel_index} !== {4'b1000, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL urgent_win: got sel=%b urg=%b idx=%0d want 1000 1 3",
               sel, sel_urgent, sel_index);
    end
    ready_urgent = '0;
    rel          = 1'b1;
    tick();
    rel = 1'b0;
    total++;
    if ({sel, sel_urgent, sel_valid} !== {4'b0001, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL urgent_then_normal: got sel=%b urg=%b valid=%b want 0001 0 1",
               sel, sel_urgent, sel_valid);
    end
    ready = '0;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    ready = 4'b0001;
    tick();
    ready_urgent = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (sel !== 4'b0001) begin
        bad++;
        $display("FAIL hold[%0d]: got sel=%b want 0001", k, sel);
      end
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    total++;
    if ({sel, sel_urgent} !== {4'b1000, 1'b1}) begin
      bad++;
      $display("FAIL hold_release: got sel=%b urg=%b want 1000 1", sel, sel_urgent);
    end
    ready        = '0;
    ready_urgent = '0;
    tick();
  endtask

  task automatic test_starve();
    do_reset();
    ready        = 4'b0001;
    ready_urgent = 4'b0010;
    tick();
    total++;
    if ({sel, promoted} !== {4'b0010, 4'b0000}) begin
      bad++;
      $display("FAIL starve_ev1: got sel=%b prom=%b want 0010 0000", sel, promoted);
    end
    ready_urgent = 4'b0100;
    rel          = 1'b1;
    tick();
    total++;
    if ({sel, promoted} !== {4'b0100, 4'b0001}) begin
      bad++;
      $display("FAIL starve_promote: got sel=%b prom=%b want 0100 0001", sel, promoted);
    end
    ready_urgent = 4'b0010;
    tick();
    rel = 1'b0;
    total++;
    if ({sel, sel_urgent, promoted} !== {4'b0001, 1'b1, 4'b0000}) begin
      bad++;
      $display("FAIL starve_grant: got sel=%b urg=%b prom=%b want 0001 1 0000",
               sel, sel_urgent, promoted);
    end
    ready        = '0;
    ready_urgent = '0;
    tick();
  endtask

  task automatic test_implicit_release();
    do_reset();
    ready = 4'b0100;
    tick();
    ready = 4'b0010;
    tick();
    total++;
    if ({sel, sel_index, sel_valid} !== {4'b0010, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL implicit_handoff: got sel=%b idx=%0d valid=%b want 0010 1 1",
               sel, sel_index, sel_valid);
    end
    ready = '0;
    tick();
    total++;
    if ({sel, sel_valid} !== {4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL implicit_idle: got sel=%b valid=%b want 0000 0", sel, sel_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_normal_rr();
    test_urgent();
    test_hold();
    test_starve();
    test_implicit_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
